mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/ea_calc.sv | 11 +
 rtl/mem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the load/store memory access controller:
// opcodes, FSM state encoding and the default memory wait budget.
package mem_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 8;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ea_calc.sv
// Effective address: base register plus sign-extended 16-bit immediate,
// wrapping modulo 2^32.
module ea_calc (
    input  logic [31:0] base,
    input  logic [15:0] imm,
    output logic [31:0] ea
);

    assign ea = base + {{16{imm[15]}}, imm};

endmodule

// File: rtl/mem_access_ctrl.sv
// Executes one MIPS LW/SW: latch operands, compute and check the address,
// run a bounded memory handshake, then report done/error and load writeback.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] Read_data1,
    input  logic [31:0] Read_data2,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic        RegWrite,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_reg, state_next;
    logic          phase_reg, phase_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [5:0]    op_reg, op_next;
    logic [4:0]    rt_reg, rt_next;
    logic [15:0]   imm_reg, imm_next;
    logic [31:0]   base_reg, base_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [31:0]   addr_reg, addr_next;
    logic          err_reg, err_next;
    logic [31:0]   wb_data_reg, wb_data_next;
    logic [4:0]    wb_reg_reg, wb_reg_next;
    logic [31:0]   ea;

    ea_calc u_ea_calc (
        .base (base_reg),
        .imm  (imm_reg),
        .ea   (ea)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= 1'b0;
            cnt_reg     <= '0;
            op_reg      <= '0;
            rt_reg      <= '0;
            imm_reg     <= '0;
            base_reg    <= '0;
            wdata_reg   <= '0;
            addr_reg    <= '0;
            err_reg     <= 1'b0;
            wb_data_reg <= '0;
            wb_reg_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            cnt_reg     <= cnt_next;
            op_reg      <= op_next;
            rt_reg      <= rt_next;
            imm_reg     <= imm_next;
            base_reg    <= base_next;
            wdata_reg   <= wdata_next;
            addr_reg    <= addr_next;
            err_reg     <= err_next;
            wb_data_reg <= wb_data_next;
            wb_reg_reg  <= wb_reg_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        cnt_next     = cnt_reg;
        op_next      = op_reg;
        rt_next      = rt_reg;
        imm_next     = imm_reg;
        base_next    = base_reg;
        wdata_next   = wdata_reg;
        addr_next    = addr_reg;
        err_next     = err_reg;
        wb_data_next = wb_data_reg;
        wb_reg_next  = wb_reg_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    op_next    = instruction[31:26];
                    rt_next    = instruction[20:16];
                    imm_next   = instruction[15:0];
                    base_next  = Read_data1;
                    wdata_next = (instruction[31:26] == OP_SW) ? Read_data2 : 32'd0;
                    err_next   = 1'b0;
                    phase_next = 1'b0;
                    cnt_next   = '0;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // First cycle registers the sum; second cycle decides on the
                // registered address so the adder never feeds the FSM directly.
                if (!phase_reg) begin
                    addr_next  = ea;
                    phase_next = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    cnt_next   = '0;
                    if ((op_reg != OP_LW && op_reg != OP_SW) || addr_reg[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_MEM;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (op_reg == OP_LW) begin
                        wb_data_next = mem_rdata;
                        wb_reg_next  = rt_reg;
                    end
                    state_next = ST_DONE;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy       = (state_reg != ST_IDLE);
    assign mem_addr   = addr_reg;
    assign Write_data = wdata_reg;
    assign MemRead    = (state_reg == ST_MEM) && (op_reg == OP_LW);
    assign MemWrite   = (state_reg == ST_MEM) && (op_reg == OP_SW);
    assign done       = (state_reg == ST_DONE);
    assign error      = (state_reg == ST_DONE) && err_reg;
    assign RegWrite   = (state_reg == ST_DONE) && !err_reg && (op_reg == OP_LW);
    assign wb_reg     = wb_reg_reg;
    assign wb_data    = wb_data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and
// compares on every done pulse; a responder plays the data memory.
module tb_mem_access_ctrl;

    localparam int TMO = 8;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;

    logic        clk = 1'b0;
    logic        reset, start, mem_ready;
    logic [31:0] instruction, Read_data1, Read_data2, mem_rdata;
    logic        busy, MemRead, MemWrite, RegWrite, done, error;
    logic [31:0] mem_addr, Write_data, wb_data;
    logic [4:0]  wb_reg;

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .Read_data1(Read_data1), .Read_data2(Read_data2),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .mem_addr(mem_addr), .MemRead(MemRead), .MemWrite(MemWrite),
        .Write_data(Write_data), .RegWrite(RegWrite), .wb_reg(wb_reg),
        .wb_data(wb_data), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic        err;
        logic        rw;
        logic [4:0]  rt;
        logic [31:0] rdata;
        logic [1:0]  kind;
        int          strobes;
        int          lat;
        int          start_edge;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          cur_wait = 0;
    logic [31:0] cur_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: outcome of one instruction from the architectural rules.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] rd1,
                                   input logic [31:0] rd2, input int wt, input logic [31:0] rdata);
        exp_t        e;
        logic [5:0]  op;
        int          imm;
        logic [31:0] sum;
        op  = instr[31:26];
        imm = int'(instr[15:0]);
        if (imm >= 32768) imm = imm - 65536;
        sum = rd1 + 32'(imm);
        e.addr      = sum;
        e.chk_wdata = (op == LW) || (op == SW);
        e.wdata     = (op == SW) ? rd2 : 32'd0;
        e.rt        = instr[20:16];
        e.rdata     = rdata;
        e.rw        = 1'b0;
        e.start_edge = 0;
        if (!((op == LW) || (op == SW)) || (sum % 4 != 0)) begin
            e.err = 1'b1; e.strobes = 0; e.kind = 2'b00; e.lat = 2;
        end else begin
            e.kind = (op == LW) ? 2'b10 : 2'b01;
            if (wt >= TMO) begin
                e.err = 1'b1; e.strobes = TMO; e.lat = 2 + TMO;
            end else begin
                e.err = 1'b0; e.strobes = wt + 1; e.lat = 3 + wt; e.rw = (op == LW);
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: raises mem_ready after cur_wait strobe cycles; junk otherwise.
    int resp_k = 0;
    always @(negedge clk) begin
        if (reset || !(MemRead || MemWrite)) begin
            resp_k    = 0;
            mem_ready = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
        end else begin
            resp_k++;
            mem_ready = (resp_k == cur_wait + 1);
            mem_rdata = mem_ready ? cur_rdata : $urandom;
        end
    end

    // Monitor: accumulates strobe behaviour, compares on each done pulse.
    int          mon_strobes = 0;
    logic [1:0]  mon_kind = 2'b00;
    logic [31:0] mon_addr, mon_wdata;
    logic        mon_unstable = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            mon_strobes = 0; mon_kind = 2'b00; mon_unstable = 1'b0;
        end else begin
            if (MemRead && MemWrite) chk("both_strobes", 32'd1, 32'd0);
            if (MemRead || MemWrite) begin
                if (mon_strobes == 0) begin
                    mon_addr = mem_addr; mon_wdata = Write_data;
                end else if (mem_addr !== mon_addr || Write_data !== mon_wdata) begin
                    mon_unstable = 1'b1;
                end
                mon_strobes++;
                mon_kind = mon_kind | {MemRead, MemWrite};
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("error", 32'(error), 32'(e.err));
                    chk("regwrite", 32'(RegWrite), 32'(e.rw));
                    chk("mem_addr", mem_addr, e.addr);
                    chk("strobe_cycles", 32'(mon_strobes), 32'(e.strobes));
                    chk("strobe_kind", 32'(mon_kind), 32'(e.kind));
                    chk("latency", 32'(cyc - e.start_edge), 32'(e.lat));
                    chk("busy_in_done", 32'(busy), 32'd1);
                    if (e.strobes > 0) chk("held_stable", 32'(mon_unstable), 32'd0);
                    if (e.chk_wdata) chk("write_data", Write_data, e.wdata);
                    if (e.rw) begin
                        chk("wb_reg", 32'(wb_reg), 32'(e.rt));
                        chk("wb_data", wb_data, e.rdata);
                    end
                    $display("[TB] txn addr=0x%08h err=%0d strobes=%0d lat=%0d", e.addr, e.err, e.strobes, e.lat);
                end
                mon_strobes = 0; mon_kind = 2'b00; mon_unstable = 1'b0;
            end
        end
    end

    task automatic run_txn(input logic [31:0] instr, input logic [31:0] rd1, input logic [31:0] rd2,
                           input int wt, input logic [31:0] rdata, input bit noise);
        exp_t e;
        bit   got;
        @(negedge clk);
        e = model(instr, rd1, rd2, wt, rdata);
        e.start_edge = cyc + 1;
        q.push_back(e);
        cur_wait = wt; cur_rdata = rdata;
        instruction = instr; Read_data1 = rd1; Read_data2 = rd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        instruction = $urandom; Read_data1 = $urandom; Read_data2 = $urandom;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (done) got = 1;
            start = noise && ($urandom_range(0, 2) == 0);
            if (start) instruction = {LW, 10'd0, 16'd0};
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] rd1;
        logic [15:0] imm;
        bit          seen;
        reset = 1'b1; start = 1'b0; instruction = 0; Read_data1 = 0; Read_data2 = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;

        run_txn({SW, 5'd4, 5'd9, 16'h0004}, 32'h10, 32'h12345678, 0, 32'h0, 0);
        run_txn({LW, 5'd4, 5'd10, 16'hFFFC}, 32'h20, 32'h0, 2, 32'hABCDEF01, 0);
        run_txn({SW, 5'd1, 5'd2, 16'h0000}, 32'h100, 32'h55AA55AA, 99, 32'h0, 0);
        run_txn({6'b000000, 5'd1, 5'd2, 16'h0000}, 32'h0, 32'h1, 0, 32'h0, 0);
        run_txn({SW, 5'd1, 5'd2, 16'h0002}, 32'h0, 32'h1, 0, 32'h0, 0);
        run_txn({LW, 5'd3, 5'd31, 16'h0008}, 32'hFFFFFFF8, 32'h0, TMO - 1, 32'h13572468, 0);

        // Reset during MEM with a simultaneous start: abort, no done, start ignored.
        @(negedge clk);
        cur_wait = 99;
        instruction = {LW, 5'd0, 5'd7, 16'h0040}; Read_data1 = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = MemRead;
        end
        chk("reached_mem", 32'(seen), 32'd1);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_memread", 32'(MemRead), 32'd0);
        chk("abort_memwrite", 32'(MemWrite), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_write_data", Write_data, 32'd0);
        chk("abort_regwrite", 32'(RegWrite), 32'd0);
        chk("abort_wb_reg", 32'(wb_reg), 32'd0);
        chk("abort_wb_data", wb_data, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_error", 32'(error), 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("reset_beats_start", 32'(busy), 32'd0);
        run_txn({LW, 5'd0, 5'd7, 16'h0040}, 32'h0, 32'h0, 1, 32'hCAFEF00D, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    op = LW;
                2, 3:    op = SW;
                default: op = 6'($urandom);
            endcase
            rd1 = $urandom;
            if ($urandom_range(0, 3) != 0) rd1[1:0] = 2'b00;
            imm = 16'($urandom);
            if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
            run_txn({op, 5'($urandom), 5'($urandom), imm}, rd1, $urandom,
                    $urandom_range(0, 10), $urandom, 1);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
